cdb_broadcast_arbiter: RTL and testbench
========================================

CDB_BROADCAST_ARBITER -- requirements
Module: cdb_broadcast_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 31, result MSB index (result width WIDTH+1).
REQ-002 SHALL have parameter ROB, default 2, ROB tag MSB index (tag width ROB+1).
REQ-003 SHALL use a single clock and a synchronous, active-high reset.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port globalReset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port clear, input, 1, misprediction flush; synchronous.
REQ-007 SHALL have port fuValid, input, 4, bit i set means unit i presents a result this cycle.
REQ-008 SHALL have port fuResult, input, 4*(WIDTH+1), unit i result in bits [i*(WIDTH+1) +: WIDTH+1].
REQ-009 SHALL have port fuRob, input, 4*(ROB+1), unit i ROB tag in bits [i*(ROB+1) +: ROB+1].
REQ-010 SHALL have port fuReady, output, 4, bit i set means unit i's input is accepted this cycle.
REQ-011 SHALL have port validBroadcast, output, 1, the CDB entry is valid this cycle.
REQ-012 SHALL have port result, output, WIDTH+1, broadcast result value.
REQ-013 SHALL have port robEntry, output, ROB+1, broadcast ROB tag.
REQ-014 SHALL have port srcUnit, output, 2, index of the unit that produced the broadcast.

Function
REQ-015 SHALL hold one single-entry buffer per unit: full flag, result, tag.
REQ-016 SHALL drive fuReady[i] combinationally as (!full[i] | grant[i]) & !clear & !globalReset.
REQ-017 SHALL capture unit i's result and tag into buffer i, and set full[i], on an edge where fuValid[i] & fuReady[i]; fuValid while not ready leaves the buffer unchanged (the unit holds its data).
REQ-018 SHALL grant at most one full buffer per cycle, combinationally, in round-robin order starting at pointer ptr (2 bits).
REQ-019 SHALL clear full[g] on the grant edge unless a new capture into buffer g occurs on the same edge, in which case full[g] stays 1 with the new data.
REQ-020 SHALL set ptr to (g+1) mod 4 on every grant edge; ptr SHALL hold when there is no grant.
REQ-021 SHALL register the granted buffer's content into result/robEntry/srcUnit and set validBroadcast=1 on the grant edge; validBroadcast SHALL be 0 after any edge without a grant.
REQ-022 Latency: a result captured at edge k SHALL be broadcast no earlier than the cycle after edge k+1; with no contention, exactly then.
REQ-023 Sustained throughput SHALL be one broadcast per cycle while any buffer is full.
REQ-024 When validBroadcast=0, result/robEntry/srcUnit SHALL hold their last values.
REQ-025 Each unit SHALL be granted within 4 grant cycles of its buffer becoming full (no starvation).
REQ-026 clear SHALL, on its edge, empty all buffers, force validBroadcast to 0 after that edge, drop any simultaneous fuValid inputs, and leave ptr unchanged.

Reset
REQ-027 globalReset SHALL, on its edge, set full[3:0]=0, ptr=0, validBroadcast=0, result=0, robEntry=0, srcUnit=0; fuReady SHALL be 0 while reset is asserted.
REQ-028 globalReset SHALL take priority over clear, capture and grant on the same edge, including reset mid-burst.

Verification
REQ-029 Reset, then fuValid=0001, fuResult[0]=0x0000_00AA, fuRob[0]=3 for one cycle -> two edges later validBroadcast=1, result=0x000000AA, robEntry=3, srcUnit=0 for exactly one cycle.
REQ-030 With ptr=0, all four units valid in the same cycle with tags 4,5,6,7 -> broadcasts on four consecutive cycles with srcUnit 0,1,2,3 and robEntry 4,5,6,7; fuReady reflects the per-unit grants.
REQ-031 Unit 2 valid every cycle with tags 1,2,3... and unit 1 buffered -> grants alternate between units 1 and 2; unit 2's fuReady stays 1 on its grant cycles and no tag is lost or duplicated.
REQ-032 Three buffers full and clear asserted together with fuValid=1000 -> the next cycle has validBroadcast=0, all fuReady=1 and no broadcast of the dropped unit-3 data; ptr is unchanged.
REQ-033 globalReset asserted mid-burst with two buffers full -> validBroadcast=0, result=0, robEntry=0 after that edge; the first broadcast after release comes from unit 0 if requests are simultaneous.

Source files
------------

// File: rtl/cdb_broadcast_arbiter.sv
// Common-data-bus broadcast arbiter: four single-entry result buffers, one per
// functional unit, drained onto the CDB one entry per cycle in round-robin order.
module cdb_broadcast_arbiter #(
  parameter int WIDTH = 31,
  parameter int ROB   = 2
) (
  input  logic                   clk,
  input  logic                   globalReset,
  input  logic                   clear,
  input  logic [3:0]             fuValid,
  input  logic [4*(WIDTH+1)-1:0] fuResult,
  input  logic [4*(ROB+1)-1:0]   fuRob,
  output logic [3:0]             fuReady,
  output logic                   validBroadcast,
  output logic [WIDTH:0]         result,
  output logic [ROB:0]           robEntry,
  output logic [1:0]             srcUnit
);

  logic [3:0]   full;
  logic [WIDTH:0] buf_result [4];
  logic [ROB:0]   buf_rob    [4];
  logic [1:0]   ptr;

  logic [3:0]   grant;
  logic [1:0]   grant_idx;
  logic         grant_any;
  logic [1:0]   scan_idx;
  logic [3:0]   capture;

  // Round-robin scan starting at ptr; first full buffer wins.
  always_comb begin
    grant     = '0;
    grant_idx = ptr;
    grant_any = 1'b0;
    scan_idx  = '0;
    for (int k = 0; k < 4; k++) begin
      scan_idx = ptr + 2'(k);
      if (!grant_any && full[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx;
      end
    end
    if (grant_any) grant[grant_idx] = 1'b1;
  end

  // A buffer being drained this cycle can accept a replacement on the same edge.
  assign fuReady = (~full | grant) & {4{~clear & ~globalReset}};
  assign capture = fuValid & fuReady;

  // NOTE: buffer payloads carry no reset; the full flags alone gate their use,
  // so leaving the storage unreset keeps it as plain registers/RAM-friendly.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (capture[i]) begin
        buf_result[i] <= fuResult[i*(WIDTH+1) +: WIDTH+1];
        buf_rob[i]    <= fuRob[i*(ROB+1) +: ROB+1];
      end
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register sees
  // the pre-edge values of grant/capture, regardless of statement order.
  always_ff @(posedge clk) begin
    if (globalReset) begin
      full           <= '0;
      ptr            <= '0;
      validBroadcast <= 1'b0;
      result         <= '0;
      robEntry       <= '0;
      srcUnit        <= '0;
    end else if (clear) begin
      full           <= '0;
      validBroadcast <= 1'b0;
    end else begin
      full           <= (full & ~grant) | capture;
      validBroadcast <= grant_any;
      if (grant_any) begin
        ptr      <= grant_idx + 2'd1;
        result   <= buf_result[grant_idx];
        robEntry <= buf_rob[grant_idx];
        srcUnit  <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_cdb_broadcast_arbiter.sv
// Self-checking bench for cdb_broadcast_arbiter: directed scenarios followed by
// random traffic, all compared against a slot-level reference model.
module tb_cdb_broadcast_arbiter;

  localparam int W = 32;
  localparam int T = 3;

  logic           clk = 1'b0;
  logic           globalReset;
  logic           clear;
  logic [3:0]     fuValid;
  logic [4*W-1:0] fuResult;
  logic [4*T-1:0] fuRob;
  logic [3:0]     fuReady;
  logic           validBroadcast;
  logic [W-1:0]   result;
  logic [T-1:0]   robEntry;
  logic [1:0]     srcUnit;

  cdb_broadcast_arbiter #(.WIDTH(W-1), .ROB(T-1)) dut (
    .clk(clk), .globalReset(globalReset), .clear(clear),
    .fuValid(fuValid), .fuResult(fuResult), .fuRob(fuRob),
    .fuReady(fuReady), .validBroadcast(validBroadcast),
    .result(result), .robEntry(robEntry), .srcUnit(srcUnit)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: one slot per unit plus the rotation pointer.
  bit           m_full [4];
  logic [W-1:0] m_res  [4];
  logic [T-1:0] m_tag  [4];
  int           m_ptr;
  bit           e_valid;
  logic [W-1:0] e_res;
  logic [T-1:0] e_tag;
  logic [1:0]   e_src;
  logic [3:0]   m_rdy;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // One clock: apply inputs, check readiness, advance the model, check the CDB.
  task automatic step(input logic rst, input logic clr, input logic [3:0] v,
                      input logic [4*W-1:0] res, input logic [4*T-1:0] tg);
    int g;
    globalReset = rst; clear = clr; fuValid = v; fuResult = res; fuRob = tg;
    g = -1;
    for (int k = 0; k < 4; k++)
      if (g < 0 && m_full[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
    for (int i = 0; i < 4; i++)
      m_rdy[i] = (!m_full[i] || g == i) && !clr && !rst;
    #1 check("fuReady", 64'(fuReady), 64'(m_rdy));
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 4; i++) m_full[i] = 0;
      m_ptr = 0; e_valid = 0; e_res = '0; e_tag = '0; e_src = '0;
    end else if (clr) begin
      for (int i = 0; i < 4; i++) m_full[i] = 0;
      e_valid = 0;
    end else begin
      e_valid = (g >= 0);
      if (g >= 0) begin
        e_res = m_res[g]; e_tag = m_tag[g]; e_src = 2'(g);
        m_full[g] = 0;
        m_ptr = (g + 1) % 4;
      end
      for (int i = 0; i < 4; i++)
        if (v[i] && m_rdy[i]) begin
          m_full[i] = 1; m_res[i] = res[i*W +: W]; m_tag[i] = tg[i*T +: T];
        end
    end
    #1;
    check("validBroadcast", 64'(validBroadcast), 64'(e_valid));
    check("result", 64'(result), 64'(e_res));
    check("robEntry", 64'(robEntry), 64'(e_tag));
    check("srcUnit", 64'(srcUnit), 64'(e_src));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'b0000, '0, '0);
  endtask

  logic [4*W-1:0] rnd_res;
  logic [T-1:0]   t1, t2, exp1, exp2;

  initial begin
    for (int i = 0; i < 4; i++) begin m_full[i] = 0; m_res[i] = '0; m_tag[i] = '0; end
    m_ptr = 0; e_valid = 0; e_res = '0; e_tag = '0; e_src = '0;

    // Reset state
    step(1'b1, 1'b0, 4'b0000, '0, '0);
    step(1'b1, 1'b0, 4'b1111, '1, '1);
    check("reset_ready_low", 64'(fuReady), 64'(4'b0000));
    check("reset_valid", 64'(validBroadcast), 64'd0);
    check("reset_result", 64'(result), 64'd0);

    // Single result, two-edge latency, one-cycle broadcast
    step(1'b0, 1'b0, 4'b0001, {96'h0, 32'h0000_00AA}, {9'h0, 3'd3});
    check("lat_not_early", 64'(validBroadcast), 64'd0);
    idle();
    check("single_valid", 64'(validBroadcast), 64'd1);
    check("single_result", 64'(result), 64'h0000_00AA);
    check("single_rob", 64'(robEntry), 64'd3);
    check("single_src", 64'(srcUnit), 64'd0);
    idle();
    check("single_once", 64'(validBroadcast), 64'd0);
    check("single_hold", 64'(result), 64'h0000_00AA);

    // Four simultaneous requests with ptr=0 -> units 0,1,2,3 in order
    step(1'b1, 1'b0, 4'b0000, '0, '0);
    step(1'b0, 1'b0, 4'b1111, {32'h33, 32'h22, 32'h11, 32'h00}, {3'd7, 3'd6, 3'd5, 3'd4});
    for (int n = 0; n < 4; n++) begin
      idle();
      check("burst_valid", 64'(validBroadcast), 64'd1);
      check("burst_src", 64'(srcUnit), 64'(n));
      check("burst_rob", 64'(robEntry), 64'(4 + n));
    end
    idle();
    check("burst_done", 64'(validBroadcast), 64'd0);

    // Units 1 and 2 streaming: grants alternate, no tag lost or duplicated
    step(1'b1, 1'b0, 4'b0000, '0, '0);
    t1 = 3'd4; t2 = 3'd1; exp1 = 3'd4; exp2 = 3'd1;
    for (int n = 0; n < 12; n++) begin
      step(1'b0, 1'b0, 4'b0110, {32'h0, 32'(t2) | 32'h200, 32'(t1) | 32'h100, 32'h0},
           {3'd0, t2, t1, 3'd0});
      if (m_rdy[1]) t1 = t1 + 3'd1;
      if (m_rdy[2]) t2 = t2 + 3'd1;
      if (n >= 1) begin
        check("alt_valid", 64'(validBroadcast), 64'd1);
        check("alt_src", 64'(srcUnit), (n % 2 == 1) ? 64'd1 : 64'd2);
        if (n % 2 == 1) begin
          check("alt_tag1", 64'(robEntry), 64'(exp1)); exp1 = exp1 + 3'd1;
        end else begin
          check("alt_tag2", 64'(robEntry), 64'(exp2)); exp2 = exp2 + 3'd1;
        end
      end
    end

    // Clear with three buffers full and a simultaneous unit-3 request
    step(1'b1, 1'b0, 4'b0000, '0, '0);
    step(1'b0, 1'b0, 4'b0111, {32'h0, 32'hC2, 32'hC1, 32'hC0}, {3'd0, 3'd2, 3'd1, 3'd0});
    step(1'b0, 1'b0, 4'b0001, {96'h0, 32'hC4}, {9'h0, 3'd4});
    step(1'b0, 1'b1, 4'b1000, {32'hDEAD, 96'h0}, {3'd5, 9'h0});
    check("clr_valid", 64'(validBroadcast), 64'd0);
    step(1'b0, 1'b0, 4'b0000, '0, '0);
    check("clr_ready_all", 64'(fuReady), 64'(4'b1111));
    check("clr_no_drop", 64'(validBroadcast), 64'd0);
    step(1'b0, 1'b0, 4'b1111, {32'hE3, 32'hE2, 32'hE1, 32'hE0}, {3'd3, 3'd2, 3'd1, 3'd0});
    idle();
    check("clr_ptr_kept", 64'(srcUnit), 64'd1);

    // Reset mid-burst with buffers full, then simultaneous requests
    step(1'b0, 1'b0, 4'b1111, {32'hF3, 32'hF2, 32'hF1, 32'hF0}, {3'd3, 3'd2, 3'd1, 3'd4});
    idle();
    step(1'b1, 1'b0, 4'b0000, '0, '0);
    check("rst_mid_valid", 64'(validBroadcast), 64'd0);
    check("rst_mid_result", 64'(result), 64'd0);
    check("rst_mid_rob", 64'(robEntry), 64'd0);
    step(1'b0, 1'b0, 4'b1111, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, {3'd3, 3'd2, 3'd1, 3'd6});
    idle();
    check("rst_first_src", 64'(srcUnit), 64'd0);
    check("rst_first_res", 64'(result), 64'hA0);

    // Random traffic with occasional clear and reset
    for (int n = 0; n < 400; n++) begin
      rnd_res = {$urandom, $urandom, $urandom, $urandom};
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
           4'($urandom), rnd_res, 12'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
